// File: rtl/sbit_occupancy_monitor_pkg.sv
// rtl/sbit_occupancy_monitor_pkg.sv - shared widths, window table and snapshot FSM encoding
package sbit_occupancy_monitor_pkg;

  localparam int SUM_W  = 20;
  localparam int OVER_W = 15;
  localparam int CNT_W  = 6;
  localparam int BX_W   = 14;
  localparam int RUN_W  = 4;

  // Window lengths in BX, indexed by win_sel.
  localparam logic [3:0][BX_W:0] WIN_LEN = {15'd16384, 15'd4096, 15'd1024, 15'd256};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } snap_state_e;

  function automatic logic [BX_W-1:0] win_last(input logic [1:0] sel);
    return BX_W'(WIN_LEN[sel] - 15'd1);
  endfunction

endpackage

// File: rtl/sbit_occupancy_monitor_hot_detect.sv
// rtl/sbit_occupancy_monitor_hot_detect.sv - run-length alarm on consecutive over-threshold BX
module sbit_hot_detect
  import sbit_occupancy_monitor_pkg::*;
(
  input  logic             lhc_clock,
  input  logic             reset,
  input  logic             lte_n,
  input  logic [RUN_W-1:0] hot_len,
  output logic             hot
);

  logic [RUN_W-1:0] run_q, run_d;
  logic             hot_q, hot_d;
  logic [RUN_W:0]   run_inc;

  // run_inc counts the current sample too, so the compare is against run+1.
  always_comb begin
    run_inc = (RUN_W+1)'(run_q) + 1'b1;
    run_d   = '0;
    hot_d   = 1'b0;
    if (!lte_n) begin
      run_d = run_inc[RUN_W] ? run_q : run_inc[RUN_W-1:0];
      hot_d = (hot_len != '0) && (run_inc >= (RUN_W+1)'(hot_len));
    end
  end

  always_ff @(posedge lhc_clock) begin
    if (reset) begin
      run_q <= '0;
      hot_q <= 1'b0;
    end else begin
      run_q <= run_d;
      hot_q <= hot_d;
    end
  end

  assign hot = hot_q;

endmodule

// File: rtl/sbit_occupancy_monitor.sv
// rtl/sbit_occupancy_monitor.sv - windowed S-bit occupancy accumulator with snapshot handoff
module sbit_occupancy_monitor
  import sbit_occupancy_monitor_pkg::*;
(
  input  logic              lhc_clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              lte_n,
  input  logic [1:0]        win_sel,
  input  logic [RUN_W-1:0]  hot_len,
  input  logic              snap_ack,
  output logic              snap_valid,
  output logic [SUM_W-1:0]  snap_sum,
  output logic [CNT_W-1:0]  snap_peak,
  output logic [OVER_W-1:0] snap_over,
  output logic              hot,
  output logic              snap_lost
);

  logic [BX_W-1:0]   bx_q, bx_d;
  logic [1:0]        sel_q, sel_d;
  logic [SUM_W-1:0]  sum_q, sum_d, sum_tot;
  logic [CNT_W-1:0]  peak_q, peak_d, peak_tot;
  logic [OVER_W-1:0] over_q, over_d, over_tot;
  logic [SUM_W-1:0]  snap_sum_q, snap_sum_d;
  logic [CNT_W-1:0]  snap_peak_q, snap_peak_d;
  logic [OVER_W-1:0] snap_over_q, snap_over_d;
  snap_state_e       state_q, state_d;
  logic              lost_q, lost_d;
  logic              close;
  logic              load;

  // Totals include the current sample so the close cycle is counted in its own window.
  always_comb begin
    sum_tot  = sum_q + SUM_W'(count_in);
    peak_tot = (count_in > peak_q) ? count_in : peak_q;
    over_tot = over_q + OVER_W'(!lte_n);
  end

  assign close = (bx_q == win_last(sel_q));

  always_comb begin
    bx_d   = close ? '0 : bx_q + 1'b1;
    sel_d  = (bx_q == '0) ? win_sel : sel_q;
    sum_d  = close ? '0 : sum_tot;
    peak_d = close ? '0 : peak_tot;
    over_d = close ? '0 : over_tot;
  end

  always_comb begin
    state_d = state_q;
    lost_d  = lost_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (close) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (close) begin
          if (snap_ack) load   = 1'b1;
          else          lost_d = 1'b1;
        end else if (snap_ack) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    snap_sum_d  = load ? sum_tot  : snap_sum_q;
    snap_peak_d = load ? peak_tot : snap_peak_q;
    snap_over_d = load ? over_tot : snap_over_q;
  end

  always_ff @(posedge lhc_clock) begin
    if (reset) begin
      bx_q        <= '0;
      sel_q       <= win_sel;
      sum_q       <= '0;
      peak_q      <= '0;
      over_q      <= '0;
      snap_sum_q  <= '0;
      snap_peak_q <= '0;
      snap_over_q <= '0;
      state_q     <= ST_EMPTY;
      lost_q      <= 1'b0;
    end else begin
      bx_q        <= bx_d;
      sel_q       <= sel_d;
      sum_q       <= sum_d;
      peak_q      <= peak_d;
      over_q      <= over_d;
      snap_sum_q  <= snap_sum_d;
      snap_peak_q <= snap_peak_d;
      snap_over_q <= snap_over_d;
      state_q     <= state_d;
      lost_q      <= lost_d;
    end
  end

  sbit_hot_detect u_hot (
    .lhc_clock (lhc_clock),
    .reset     (reset),
    .lte_n     (lte_n),
    .hot_len   (hot_len),
    .hot       (hot)
  );

  assign snap_valid = (state_q == ST_FULL);
  assign snap_sum   = snap_sum_q;
  assign snap_peak  = snap_peak_q;
  assign snap_over  = snap_over_q;
  assign snap_lost  = lost_q;

endmodule

// File: tb/tb_sbit_occupancy_monitor.sv
// tb/tb_sbit_occupancy_monitor.sv - scoreboard bench for sbit_occupancy_monitor
module tb_sbit_occupancy_monitor;

  logic        lhc_clock = 1'b0;
  logic        reset;
  logic [5:0]  count_in;
  logic        lte_n;
  logic [1:0]  win_sel;
  logic [3:0]  hot_len;
  logic        snap_ack;
  logic        snap_valid;
  logic [19:0] snap_sum;
  logic [5:0]  snap_peak;
  logic [14:0] snap_over;
  logic        hot;
  logic        snap_lost;

  always #5 lhc_clock = ~lhc_clock;

  sbit_occupancy_monitor dut (
    .lhc_clock  (lhc_clock),
    .reset      (reset),
    .count_in   (count_in),
    .lte_n      (lte_n),
    .win_sel    (win_sel),
    .hot_len    (hot_len),
    .snap_ack   (snap_ack),
    .snap_valid (snap_valid),
    .snap_sum   (snap_sum),
    .snap_peak  (snap_peak),
    .snap_over  (snap_over),
    .hot        (hot),
    .snap_lost  (snap_lost)
  );

  typedef struct {
    logic        valid;
    logic [19:0] sum;
    logic [5:0]  peak;
    logic [14:0] over;
    logic        hot;
    logic        lost;
    logic        chk_snap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the open window is kept as a list of raw samples.
  int        win_cnt[$];
  bit        win_lte[$];
  int        win_len = 256;
  bit        m_valid, m_lost, m_hot;
  int        m_sum, m_peak, m_over;
  bit [15:0] m_hist;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    int   s, p, o;
    if (reset) begin
      win_cnt.delete();
      win_lte.delete();
      m_valid = 0; m_lost = 0; m_hot = 0;
      m_sum = 0; m_peak = 0; m_over = 0;
      m_hist = '1;
      e.chk_snap = 1;
    end else begin
      if (win_cnt.size() == 0) win_len = 256 << (2 * int'(win_sel));
      win_cnt.push_back(int'(count_in));
      win_lte.push_back(lte_n);
      m_hist = {m_hist[14:0], lte_n};
      m_hot = (hot_len != 0);
      for (int i = 0; i < int'(hot_len); i++) if (m_hist[i]) m_hot = 0;
      if (win_cnt.size() == win_len) begin
        s = 0; p = 0; o = 0;
        foreach (win_cnt[i]) begin
          s += win_cnt[i];
          if (win_cnt[i] > p) p = win_cnt[i];
          if (!win_lte[i]) o++;
        end
        if (!m_valid || snap_ack) begin
          m_valid = 1; m_sum = s; m_peak = p; m_over = o;
        end else begin
          m_lost = 1;
        end
        win_cnt.delete();
        win_lte.delete();
      end else if (snap_ack) begin
        m_valid = 0;
      end
      e.chk_snap = m_valid;
    end
    e.valid = m_valid;
    e.sum   = 20'(m_sum);
    e.peak  = 6'(m_peak);
    e.over  = 15'(m_over);
    e.hot   = m_hot;
    e.lost  = m_lost;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge lhc_clock);
    model_step();
    @(negedge lhc_clock);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge lhc_clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_valid", snap_valid, e.valid);
        check("sb_hot", hot, e.hot);
        check("sb_lost", snap_lost, e.lost);
        if (e.chk_snap) begin
          check("sb_sum", snap_sum, e.sum);
          check("sb_peak", snap_peak, e.peak);
          check("sb_over", snap_over, e.over);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int g_sum;
    reset = 1; count_in = 0; lte_n = 1; win_sel = 0; hot_len = 0; snap_ack = 0;
    repeat (3) step();
    check("rst_valid", snap_valid, 0);
    check("rst_sum", snap_sum, 0);
    check("rst_hot", hot, 0);
    check("rst_lost", snap_lost, 0);
    reset = 0;

    count_in = 3; lte_n = 1;
    repeat (256) step();
    check("a_valid", snap_valid, 1);
    check("a_sum", snap_sum, 768);
    check("a_peak", snap_peak, 3);
    check("a_over", snap_over, 0);

    count_in = 24; lte_n = 0;
    snap_ack = 1; step(); snap_ack = 0;
    repeat (255) step();
    check("b1_sum", snap_sum, 6144);
    check("b1_peak", snap_peak, 24);
    check("b1_over", snap_over, 256);
    snap_ack = 1; step(); snap_ack = 0;
    repeat (255) step();
    check("b2_valid", snap_valid, 1);
    check("b2_sum", snap_sum, 6144);
    check("b2_over", snap_over, 256);
    check("b2_lost", snap_lost, 0);

    count_in = 5; lte_n = 1;
    repeat (256) step();
    check("c_valid", snap_valid, 1);
    check("c_sum_kept", snap_sum, 6144);
    check("c_lost", snap_lost, 1);

    reset = 1; step(); reset = 0;
    check("c_lost_rst", snap_lost, 0);
    count_in = 7;
    repeat (256) step();
    count_in = 9;
    repeat (255) step();
    snap_ack = 1; step(); snap_ack = 0;
    check("d_valid", snap_valid, 1);
    check("d_sum", snap_sum, 2304);
    check("d_peak", snap_peak, 9);
    check("d_lost", snap_lost, 0);

    hot_len = 4; count_in = 1;
    lte_n = 1; step();
    lte_n = 0;
    repeat (3) begin step(); check("e_hot_short", hot, 0); end
    lte_n = 1; step(); check("e_hot_short_end", hot, 0);
    lte_n = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("e_hot_run", hot, (i >= 4) ? 1 : 0);
    end
    lte_n = 1; step(); check("e_hot_clear", hot, 0);
    hot_len = 0;

    reset = 1; win_sel = 0; step(); reset = 0;
    count_in = 2; lte_n = 1;
    repeat (100) step();
    win_sel = 3;
    repeat (155) step();
    check("f_valid_early", snap_valid, 0);
    step();
    check("f_valid", snap_valid, 1);
    check("f_sum", snap_sum, 512);
    snap_ack = 1; step(); snap_ack = 0;
    repeat (16382) begin lte_n = 1'($urandom); step(); end
    check("f_long_early", snap_valid, 0);
    step();
    check("f_long_valid", snap_valid, 1);
    check("f_long_sum", snap_sum, 32768);

    win_sel = 0; hot_len = 2; lte_n = 0; count_in = 4;
    repeat (100) step();
    check("g_pre_hot", hot, 1);
    check("g_pre_valid", snap_valid, 1);
    reset = 1; step(); reset = 0;
    check("g_rst_valid", snap_valid, 0);
    check("g_rst_sum", snap_sum, 0);
    check("g_rst_peak", snap_peak, 0);
    check("g_rst_over", snap_over, 0);
    check("g_rst_hot", hot, 0);
    check("g_rst_lost", snap_lost, 0);
    hot_len = 0;
    g_sum = 0;
    repeat (255) begin
      count_in = 6'($urandom_range(0, 63)); lte_n = 1'($urandom);
      g_sum += int'(count_in);
      step();
    end
    check("g_valid_early", snap_valid, 0);
    count_in = 6'($urandom_range(0, 63));
    g_sum += int'(count_in);
    step();
    check("g_valid", snap_valid, 1);
    check("g_sum", snap_sum, 32'(g_sum));

    for (int i = 0; i < 8000; i++) begin
      count_in = 6'($urandom_range(0, 63));
      lte_n    = ($urandom_range(0, 99) < 65) ? 1'b0 : 1'b1;
      snap_ack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) win_sel = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) hot_len = 4'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 2999) == 0);
      step();
    end
    reset = 0; snap_ack = 0;
    step();
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
